cdma_scope_render: RTL and testbench
====================================

CDMA_SCOPE_RENDER -- requirements
Module: cdma_scope_render

Interface
REQ-001 SHALL have parameter TRACE_RGB, 24'h00FF00, colour of the waveform trace.
REQ-002 SHALL have parameter AXIS_RGB, 24'h808080, colour of the horizontal zero axis.
REQ-003 SHALL have parameter GRID_RGB, 24'h303030, colour of the vertical grid lines.
REQ-004 SHALL have port vga_clk  in  1  pixel clock, the only clock; all logic on the rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port sample_valid  in  1  upstream despread-sample strobe.
REQ-007 SHALL have port sample_data  in  8  two's-complement sample.
REQ-008 SHALL have port sample_ready  out  1  high while the write buffer accepts samples.
REQ-009 SHALL have port CoorX  in  11  pixel column, 0..639 active, 640 means blank.
REQ-010 SHALL have port CoorY  in  10  pixel row, 0..479 active, 480 means blank.
REQ-011 SHALL have ports BLANK_n, HS and VS  in  1 each  timing inputs from the VGA timing generator.
REQ-012 SHALL have ports VGA_R, VGA_G and VGA_B  out  8 each  pixel colour.
REQ-013 SHALL have ports BLANK_n_o, HS_o and VS_o  out  1 each  timing inputs delayed to match the pixel output.
REQ-014 SHALL have port frame_swap  out  1  one-cycle pulse when the buffers swap.

Function
REQ-015 SHALL hold two 640x8 sample banks: a write bank (filled from the sample stream) and a display bank (read by CoorX); disp_sel selects the display bank.
REQ-016 SHALL run a write FSM with states FILL and DONE; sample_ready = (state==FILL), decoded from the registered state.
REQ-017 SHALL, in FILL, write sample_data to write-bank address wr_ptr on each cycle with sample_valid && sample_ready, then increment wr_ptr.
REQ-018 SHALL, on accepting the write at wr_ptr==639, enter DONE so that sample_ready is low on the next cycle; samples offered in DONE are ignored.
REQ-019 SHALL detect the frame boundary as the cycle where registered CoorY changes from a value <480 to 480.
REQ-020 SHALL, at a frame boundary in DONE: toggle disp_sel, pulse frame_swap for one cycle, clear wr_ptr to 0 and return to FILL.
REQ-021 SHALL, at a frame boundary in FILL: not swap and not pulse frame_swap, keep filling, and keep displaying the old bank.
REQ-022 SHALL, when a sample write and the frame boundary fall on the same cycle, perform the write first and evaluate the FSM state after that write.
REQ-023 SHALL compute trace row y = 240 - sample (signed, 11-bit), giving rows 113..368.
REQ-024 SHALL register the previous column's y, and at CoorX==0 SHALL take the previous y as equal to the current y.
REQ-025 SHALL light a trace pixel when CoorY lies between min(y_prev, y) and max(y_prev, y), inclusive.
REQ-026 SHALL colour pixels by priority: trace TRACE_RGB, then axis (CoorY==240) AXIS_RGB, then grid (CoorX[5:0]==0) GRID_RGB, otherwise 0.
REQ-027 SHALL output RGB 0 whenever the delayed BLANK_n is low, CoorX==640 or CoorY==480.
REQ-028 SHALL have a latency of exactly 2 vga_clk cycles from CoorX/CoorY/BLANK_n/HS/VS in to VGA_RGB/BLANK_n_o/HS_o/VS_o out (RAM read stage + colour stage).

Reset
REQ-029 SHALL, on reset: set VGA_R/G/B = 0, BLANK_n_o = 0, HS_o = 1, VS_o = 1, frame_swap = 0, disp_sel = 0, state = FILL, wr_ptr = 0 and clear the pipeline registers.
REQ-030 SHALL NOT initialise sample bank contents on reset; a partial fill in progress at reset SHALL be discarded.

Structure
REQ-031 SHALL place H_ACTIVE = 640, V_ACTIVE = 480, AXIS_ROW = 240, GRID_MASK and the FSM state enum in the shared package cdma_vga_pkg.
REQ-032 SHALL implement storage as a single sub-module cdma_trace_ram: simple dual-port, 1280x8, with the bank bit as the address MSB, one write port and one registered read port.

Verification
REQ-033 SHALL check: reset asserted mid-fill (wr_ptr = 300) -> next cycle sample_ready = 1, wr_ptr = 0, RGB = 0, frame_swap = 0.
REQ-034 SHALL check: 640 samples, all value 0, sent, then frame boundary -> frame_swap pulses once; next frame row 240 shows TRACE_RGB in every active column.
REQ-035 SHALL check: only 639 samples sent before the boundary -> no swap, sample_ready stays 1, the 640th sample is accepted and the swap occurs at the next boundary.
REQ-036 SHALL check: samples +127 then -128 in adjacent columns -> that column lit from row 113 to row 368 inclusive.
REQ-037 SHALL check: pixel (64,100) with no trace -> GRID_RGB; pixel (64,240) -> AXIS_RGB; outputs appear 2 cycles after the coordinate, and HS_o/VS_o equal HS/VS delayed by 2.
REQ-038 SHALL check: 641st sample offered in DONE -> ignored, sample_ready = 0, bank contents unchanged.

Source files
------------

// File: rtl/cdma_vga_pkg.sv
// Shared raster constants and write-FSM encoding for the scope renderer.
package cdma_vga_pkg;
    localparam logic [10:0] H_ACTIVE  = 11'd640;
    localparam logic [9:0]  V_ACTIVE  = 10'd480;
    localparam logic [9:0]  AXIS_ROW  = 10'd240;
    localparam logic [5:0]  GRID_MASK = 6'h3F;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_DONE = 1'b1
    } wr_state_e;
endpackage

// File: rtl/cdma_trace_ram.sv
// Simple dual-port 2x640x8 sample store; address MSB selects the bank.
module cdma_trace_ram
    import cdma_vga_pkg::*;
(
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [10:0] waddr_i,
    input  logic [7:0]  wdata_i,
    input  logic [10:0] raddr_i,
    output logic [7:0]  rdata_o
);

    logic [7:0] mem_q [0:1][0:639];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i[10]][waddr_i[9:0]] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i[10]][raddr_i[9:0]];
    end

endmodule

// File: rtl/cdma_scope_render.sv
// Oscilloscope-style renderer: double-buffered sample capture and a
// two-stage pixel pipeline (RAM read, then colour).
//   state   | meaning
//   ST_FILL | write bank accepting samples
//   ST_DONE | write bank full, waiting for a frame boundary to swap
module cdma_scope_render
    import cdma_vga_pkg::*;
#(
    parameter logic [23:0] TRACE_RGB = 24'h00FF00,
    parameter logic [23:0] AXIS_RGB  = 24'h808080,
    parameter logic [23:0] GRID_RGB  = 24'h303030
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [7:0]  sample_data,
    output logic        sample_ready,
    input  logic [10:0] CoorX,
    input  logic [9:0]  CoorY,
    input  logic        BLANK_n,
    input  logic        HS,
    input  logic        VS,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        BLANK_n_o,
    output logic        HS_o,
    output logic        VS_o,
    output logic        frame_swap
);

    wr_state_e   state_q, state_d;
    logic [9:0]  wr_ptr_q, wr_ptr_d;
    logic        disp_sel_q, disp_sel_d;
    logic        frame_swap_q, frame_swap_d;

    logic [10:0] cx1_q;
    logic [9:0]  cy1_q, cy_prev_q;
    logic        blk1_q, hs1_q, vs1_q;
    logic [10:0] y_prev_q;
    logic [23:0] rgb_q;
    logic        blk2_q, hs2_q, vs2_q;

    logic        wr_en;
    logic [9:0]  rd_col;
    logic [7:0]  rd_data;
    logic        frame_edge;
    logic [10:0] y_cur, y_prv, y_lo, y_hi;
    logic        lit, on_axis, on_grid, blanked;
    logic [23:0] rgb_d;

    assign sample_ready = (state_q == ST_FILL);
    assign wr_en        = sample_valid && sample_ready;
    assign rd_col       = (CoorX < H_ACTIVE) ? CoorX[9:0] : 10'd0;
    assign frame_edge   = (cy1_q == V_ACTIVE) && (cy_prev_q < V_ACTIVE);

    cdma_trace_ram u_ram (
        .clk_i   (vga_clk),
        .we_i    (wr_en),
        .waddr_i ({~disp_sel_q, wr_ptr_q}),
        .wdata_i (sample_data),
        .raddr_i ({disp_sel_q, rd_col}),
        .rdata_o (rd_data)
    );

    // The write is applied before the swap decision, so the last sample and
    // the boundary may coincide.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        disp_sel_d   = disp_sel_q;
        frame_swap_d = 1'b0;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 10'd1;
            if (wr_ptr_q == H_ACTIVE[9:0] - 10'd1) begin
                state_d = ST_DONE;
            end
        end
        if (frame_edge && (state_d == ST_DONE)) begin
            disp_sel_d   = ~disp_sel_q;
            frame_swap_d = 1'b1;
            wr_ptr_d     = 10'd0;
            state_d      = ST_FILL;
        end
    end

    always_comb begin
        y_cur   = {1'b0, AXIS_ROW} - {{3{rd_data[7]}}, rd_data};
        y_prv   = (cx1_q == 11'd0) ? y_cur : y_prev_q;
        y_lo    = (y_cur < y_prv) ? y_cur : y_prv;
        y_hi    = (y_cur < y_prv) ? y_prv : y_cur;
        lit     = ({1'b0, cy1_q} >= y_lo) && ({1'b0, cy1_q} <= y_hi);
        on_axis = (cy1_q == AXIS_ROW);
        on_grid = ((cx1_q[5:0] & GRID_MASK) == 6'd0);
        blanked = !blk1_q || (cx1_q >= H_ACTIVE) || (cy1_q >= V_ACTIVE);
        rgb_d   = 24'd0;
        if (!blanked) begin
            if (lit)          rgb_d = TRACE_RGB;
            else if (on_axis) rgb_d = AXIS_RGB;
            else if (on_grid) rgb_d = GRID_RGB;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q      <= ST_FILL;
            wr_ptr_q     <= 10'd0;
            disp_sel_q   <= 1'b0;
            frame_swap_q <= 1'b0;
            cx1_q        <= 11'd0;
            cy1_q        <= 10'd0;
            cy_prev_q    <= 10'd0;
            blk1_q       <= 1'b0;
            hs1_q        <= 1'b1;
            vs1_q        <= 1'b1;
            y_prev_q     <= 11'd0;
            rgb_q        <= 24'd0;
            blk2_q       <= 1'b0;
            hs2_q        <= 1'b1;
            vs2_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            disp_sel_q   <= disp_sel_d;
            frame_swap_q <= frame_swap_d;
            cx1_q        <= CoorX;
            cy1_q        <= CoorY;
            cy_prev_q    <= cy1_q;
            blk1_q       <= BLANK_n;
            hs1_q        <= HS;
            vs1_q        <= VS;
            y_prev_q     <= y_cur;
            rgb_q        <= rgb_d;
            blk2_q       <= blk1_q;
            hs2_q        <= hs1_q;
            vs2_q        <= vs1_q;
        end
    end

    assign VGA_R      = rgb_q[23:16];
    assign VGA_G      = rgb_q[15:8];
    assign VGA_B      = rgb_q[7:0];
    assign BLANK_n_o  = blk2_q;
    assign HS_o       = hs2_q;
    assign VS_o       = vs2_q;
    assign frame_swap = frame_swap_q;

endmodule

// File: tb/tb_cdma_scope_render.sv
// Bench for cdma_scope_render: raster-level image model plus directed
// fill/swap/render scenarios.
`timescale 1ns/1ps
module tb_cdma_scope_render;

    localparam logic [23:0] TRACE = 24'h00FF00;
    localparam logic [23:0] AXIS  = 24'h808080;
    localparam logic [23:0] GRID  = 24'h303030;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [7:0]  sample_data;
    logic        sample_ready;
    logic [10:0] CoorX;
    logic [9:0]  CoorY;
    logic        BLANK_n, HS, VS;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        BLANK_n_o, HS_o, VS_o, frame_swap;

    always #5 vga_clk = ~vga_clk;

    cdma_scope_render dut (
        .vga_clk      (vga_clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .CoorX        (CoorX),
        .CoorY        (CoorY),
        .BLANK_n      (BLANK_n),
        .HS           (HS),
        .VS           (VS),
        .VGA_R        (VGA_R),
        .VGA_G        (VGA_G),
        .VGA_B        (VGA_B),
        .BLANK_n_o    (BLANK_n_o),
        .HS_o         (HS_o),
        .VS_o         (VS_o),
        .frame_swap   (frame_swap)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Image model: what the write bank holds and what is on screen.
    logic [7:0] wimg [640];
    logic [7:0] disp_img [640];
    bit         disp_known = 0;
    int         wcnt = 0;

    typedef struct {
        int x;
        int y;
        bit blk;
        bit hs;
        bit vs;
        bit rst;
    } hist_t;

    hist_t d1 = '{x:640, y:0, blk:0, hs:1, vs:1, rst:1};
    hist_t d2 = '{x:640, y:0, blk:0, hs:1, vs:1, rst:1};
    hist_t d3 = '{x:640, y:0, blk:0, hs:1, vs:1, rst:1};

    always @(posedge vga_clk) begin
        d3 <= d2;
        d2 <= d1;
        d1 <= '{x:int'(CoorX), y:int'(CoorY), blk:BLANK_n, hs:HS, vs:VS, rst:reset};
    end

    function automatic int yrow(input logic [7:0] s);
        return 240 - int'($signed(s));
    endfunction

    function automatic logic [23:0] exp_pix(input int x, input int y);
        int yc, yp, lo, hi;
        yc = yrow(disp_img[x]);
        yp = (x == 0) ? yc : yrow(disp_img[x-1]);
        lo = (yc < yp) ? yc : yp;
        hi = (yc < yp) ? yp : yc;
        if (y >= lo && y <= hi) return TRACE;
        if (y == 240) return AXIS;
        if (x % 64 == 0) return GRID;
        return 24'd0;
    endfunction

    int          swap_hi = 0, swap_rise = 0;
    bit          fs_prev = 0;
    int          phase = 0;
    logic [23:0] rgb, e;
    logic [23:0] cap_64_100, cap_64_240;
    int          row240_trace = 0;
    int          lit_cnt = 0, lit_min = 9999, lit_max = -1;

    always @(negedge vga_clk) begin
        rgb = {VGA_R, VGA_G, VGA_B};
        if (frame_swap) swap_hi++;
        if (frame_swap && !fs_prev) swap_rise++;
        fs_prev = frame_swap;
        if (!d1.rst && !d2.rst) begin
            check("hs_o", HS_o, d2.hs);
            check("vs_o", VS_o, d2.vs);
            check("blank_o", BLANK_n_o, d2.blk);
            if (!d2.blk || d2.x >= 640 || d2.y >= 480) begin
                check("rgb_blank", rgb, 0);
            end else if (disp_known && (d2.x == 0 || (d3.x == d2.x - 1 && !d3.rst))) begin
                e = exp_pix(d2.x, d2.y);
                check("rgb", rgb, e);
                if (d2.x == 64 && d2.y == 100) cap_64_100 = rgb;
                if (d2.x == 64 && d2.y == 240) cap_64_240 = rgb;
                if (phase == 1 && d2.y == 240 && rgb == TRACE) row240_trace++;
                if (phase == 2 && d2.x == 11 && rgb == TRACE) begin
                    lit_cnt++;
                    if (d2.y < lit_min) lit_min = d2.y;
                    if (d2.y > lit_max) lit_max = d2.y;
                end
            end
        end
    end

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        @(negedge vga_clk);
        check("sample_ready", sample_ready, wcnt < 640);
        step();
        if (wcnt < 640) begin
            wimg[wcnt] = d;
            wcnt++;
        end
    endtask

    task automatic idle(input int n);
        CoorX   = 11'd640;
        BLANK_n = 1'b0;
        repeat (n) step();
    endtask

    task automatic boundary(input bit expect_swap);
        int r0, h0;
        r0 = swap_rise;
        h0 = swap_hi;
        CoorX   = 11'd640;
        BLANK_n = 1'b0;
        CoorY   = 10'd480;
        repeat (4) step();
        CoorY = 10'd0;
        repeat (3) step();
        check("swap_pulses", swap_rise - r0, expect_swap);
        check("swap_width", swap_hi - h0, expect_swap);
        if (expect_swap) begin
            disp_img   = wimg;
            disp_known = 1;
            wcnt       = 0;
        end
        @(negedge vga_clk);
        check("ready_after_frame", sample_ready, 1);
        step();
    endtask

    task automatic scan(input int row, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) begin
            CoorX   = 11'(x);
            CoorY   = 10'(row);
            BLANK_n = 1'b1;
            HS      = 1'($urandom_range(0, 1));
            VS      = 1'($urandom_range(0, 1));
            step();
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        if (i == 10) return 8'h7F;
        if (i == 11) return 8'h80;
        return 8'd60;
    endfunction

    initial begin
        reset = 1'b1; sample_valid = 1'b0; sample_data = 8'd0;
        CoorX = 11'd640; CoorY = 10'd0; BLANK_n = 1'b0; HS = 1'b0; VS = 1'b0;
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        check("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
        check("rst_blank_o", BLANK_n_o, 0);
        check("rst_hs_o", HS_o, 1);
        check("rst_vs_o", VS_o, 1);
        check("rst_frame_swap", frame_swap, 0);
        check("rst_ready", sample_ready, 1);
        step();
        reset = 1'b0; HS = 1'b1; VS = 1'b1;

        // partial fill, then reset discards it
        for (int i = 0; i < 300; i++) send(8'(i));
        sample_valid = 1'b0;
        reset = 1'b1;
        step();
        @(negedge vga_clk);
        check("midfill_ready", sample_ready, 1);
        check("midfill_rgb", {VGA_R, VGA_G, VGA_B}, 0);
        check("midfill_swap", frame_swap, 0);
        step();
        reset = 1'b0;
        wcnt  = 0;

        // full frame of zeros, plus one extra offered while full
        for (int i = 0; i < 640; i++) send(8'd0);
        send(8'd55);
        sample_valid = 1'b0;
        @(negedge vga_clk);
        check("done_ready_low", sample_ready, 0);
        step();
        boundary(wcnt == 640);

        phase = 1;
        row240_trace = 0;
        cap_64_100 = 24'hFFFFFF;
        scan(240, 0, 639);
        idle(3);
        check("row240_all_trace", row240_trace, 640);
        scan(100, 0, 127);
        idle(3);
        check("grid_64_100_img1", cap_64_100, GRID);

        // 639 samples is not enough to swap
        for (int i = 0; i < 639; i++) send(pat(i));
        sample_valid = 1'b0;
        boundary(wcnt == 640);
        send(pat(639));
        sample_valid = 1'b0;
        boundary(wcnt == 640);

        phase = 2;
        cap_64_100 = 24'hFFFFFF;
        cap_64_240 = 24'hFFFFFF;
        scan(240, 0, 127);
        scan(100, 0, 127);
        idle(3);
        check("axis_64_240", cap_64_240, AXIS);
        check("grid_64_100", cap_64_100, GRID);

        lit_cnt = 0; lit_min = 9999; lit_max = -1;
        for (int r = 110; r <= 372; r++) scan(r, 10, 11);
        idle(3);
        check("col11_lit_count", lit_cnt, 256);
        check("col11_lit_top", lit_min, 113);
        check("col11_lit_bottom", lit_max, 368);
        check("total_swaps", swap_rise, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
